cache_ctrl: RTL
===============

// Module: cache_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache controller between CPU datapath and memory.
//  Exposes its 4-bit state register on cs. The hit/miss counter samples cs on negedge clk.
//  Hit/miss states (RDHIT=9, WRHIT=6, RDMISS=2, WRMISS=7) are held exactly one cycle per access, so each access counts once.
// PARAMETERS
//  LINES       16  number of cache lines (power of 2)
//  LINE_WORDS  4   32-bit words per line (power of 2); refill burst length
//  AW          32  byte address width
//  DW          32  data width (fixed 32)
// PORTS
//  clk        in   1   clock; all state changes on posedge
//  rst        in   1   synchronous active-low reset
//  cpu_req    in   1   access request; held high until cpu_ready
//  cpu_we     in   1   1=write, 0=read; stable while cpu_req
//  cpu_addr   in   AW  word-aligned byte address; stable while cpu_req
//  cpu_wdata  in   DW  write data
//  cpu_rdata  out  DW  read data; valid while cpu_ready on a read
//  cpu_ready  out  1   one-cycle completion pulse
//  mem_req    out  1   memory request; held until mem_ack
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory word address (byte units)
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data; valid with mem_ack
//  mem_ack    in   1   one-cycle beat acknowledge
//  cs         out  4   current state code
// BEHAVIOUR
//  Address split: offset=addr[log2(LINE_WORDS)+1:2], index=next log2(LINES) bits, tag=remaining upper bits.
//  State codes: IDLE=0, RDMISS=2, FILL=3, RDDONE=4, WRMEM=5, WRHIT=6, WRMISS=7, WRDONE=8, RDHIT=9, FLUSH=10. All other codes unused; an unused code returns to IDLE next cycle.
//  Reset (rst=0 at posedge): cs=IDLE, all valid bits=0, mem_req=0, mem_we=0, cpu_ready=0, cpu_rdata=0, mem_addr=0, mem_wdata=0, beat counter=0.
//   Reset mid-burst or mid-write abandons the transfer. Late mem_ack is ignored.
//  IDLE: cpu_req is sampled only here. Tag compare is combinational against the array.
//   read & hit  -> RDHIT
//   read & miss -> RDMISS
//   write & hit -> WRHIT
//   write & miss -> WRMISS
//  RDHIT: cpu_ready=1, cpu_rdata=line word -> IDLE. Read-hit latency is 1 cycle after cpu_req is sampled.
//  RDMISS: latch line base address, beat=0, assert mem_req (mem_we=0) -> FILL.
//  FILL: on mem_ack, write mem_rdata into word[beat] and beat++.
//   The requested word is also captured for return.
//   On the last beat: set tag, valid=1, drop mem_req -> RDDONE. Otherwise mem_addr advances by 4.
//  RDDONE: cpu_ready=1 with captured word -> IDLE.
//  WRHIT: update cached word with cpu_wdata -> WRMEM.
//  WRMISS: cache is not modified -> WRMEM.
//  WRMEM: mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata; wait for mem_ack -> WRDONE.
//  WRDONE: cpu_ready=1 -> IDLE.
//  mem_ack outside FILL/WRMEM is ignored. mem_ack may arrive in the same cycle mem_req rises.
//  beat counter wraps naturally at LINE_WORDS.
// CONFIGURATION
//  CACHE_FLUSH_EN defined:
//   adds input port flush (1 bit).
//   flush sampled in IDLE has priority over cpu_req -> FLUSH.
//   FLUSH clears one valid bit per cycle, index 0..LINES-1, then -> IDLE (LINES cycles). cpu_ready stays 0.
//  CACHE_FLUSH_EN undefined: no flush port; code 10 is never entered.
// STRUCTURE
//  cache_pkg: state code localparams (ST_IDLE..ST_FLUSH) and address-field width functions.
//  Sub-module cache_array: valid/tag/data storage.
//   Combinational read, synchronous word write, synchronous per-line valid clear and global clear.
//  cache_ctrl: FSM, beat counter, memory/CPU handshakes.
// TESTING
//  Reset with random array contents, then read 0x40 with mem_ack after 2 cycles per beat:
//   cs=0,2,3...,4,0; 4 beats at 0x40,0x44,0x48,0x4C; cpu_rdata=word@0x40.
//  Reread 0x44 -> cs=9 for exactly one cycle; cpu_ready next cycle after request; no mem_req.
//  Write 0x48=0xDEADBEEF (hit) -> cs=6,5,8; mem write observed.
//   Subsequent read 0x48 hits and returns 0xDEADBEEF.
//  Write miss 0x1000 -> cs=7,5,8; read 0x1000 then misses (cs=2), proving no allocate.
//  Deassert rst during FILL beat 2 -> cs=0, mem_req=0 next cycle; read 0x40 then misses.
//  With CACHE_FLUSH_EN: flush after fill -> cs=10 for LINES cycles; read 0x40 then misses (cs=2).

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : State codes and address-field width helpers shared by the
//            cache controller and its storage array.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // State codes are exposed on cs, so their values are fixed
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_RDMISS = 4'd2;
    localparam logic [3:0] ST_FILL   = 4'd3;
    localparam logic [3:0] ST_RDDONE = 4'd4;
    localparam logic [3:0] ST_WRMEM  = 4'd5;
    localparam logic [3:0] ST_WRHIT  = 4'd6;
    localparam logic [3:0] ST_WRMISS = 4'd7;
    localparam logic [3:0] ST_WRDONE = 4'd8;
    localparam logic [3:0] ST_RDHIT  = 4'd9;
    localparam logic [3:0] ST_FLUSH  = 4'd10;

    // Word-select field width inside a line
    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index field width
    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: whatever remains above index, offset and the byte bits
    function automatic int tag_bits(input int aw, input int lines, input int line_words);
        return aw - $clog2(lines) - $clog2(line_words) - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_array.sv
`default_nettype none
// ============================================================================
// Module   : cache_array
// Brief    : Valid/tag/data storage for the direct-mapped cache.
//            Combinational read port, synchronous word write, synchronous
//            tag+valid set, per-line valid clear and global valid clear.
// Revision : 1.0 - initial release
// ============================================================================
module cache_array import cache_pkg::*; #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 4,
    parameter int OFF_W      = 2,
    parameter int TAG_W      = 24,
    parameter int DW         = 32
) (
    input  logic             clk,
    // global valid clear (highest priority)
    input  logic             clr_all,
    // lookup port
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_offset,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [DW-1:0]    rd_word,
    // word write port
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_offset,
    input  logic [DW-1:0]    wr_data,
    // line validate port
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_index,
    input  logic [TAG_W-1:0] set_tag,
    // single-line invalidate port
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_index
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [DW-1:0]    r_data [LINES*LINE_WORDS];

    logic [IDX_W+OFF_W-1:0] w_rd_addr;
    logic [IDX_W+OFF_W-1:0] w_wr_addr;

    assign w_rd_addr = {rd_index, rd_offset};
    assign w_wr_addr = {wr_index, wr_offset};

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_word  = r_data[w_rd_addr];

    // Valid bits: global clear wins, otherwise set on refill / clear on flush
    always_ff @(posedge clk) begin
        if (clr_all) begin
            r_valid <= '0;
        end else begin
            if (set_en) begin
                r_valid[set_index] <= 1'b1;
            end
            if (clr_en) begin
                r_valid[clr_index] <= 1'b0;
            end
        end
    end

    // Tag written when a refilled line becomes valid
    always_ff @(posedge clk) begin
        if (set_en) begin
            r_tag[set_index] <= set_tag;
        end
    end

    // Data words: refill beats and write hits
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_data[w_wr_addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Brief    : Direct-mapped, write-through, no-write-allocate data cache
//            controller between the CPU datapath and memory.
//            Optional feature macro CACHE_FLUSH_EN adds a flush input that
//            invalidates every line, one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl import cache_pkg::*; #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
`ifdef CACHE_FLUSH_EN
    input  logic          flush,
`endif
    output logic [3:0]    cs
);

    localparam int c_off_w = off_bits(LINE_WORDS);
    localparam int c_idx_w = idx_bits(LINES);
    localparam int c_tag_w = tag_bits(AW, LINES, LINE_WORDS);
    localparam int c_lo    = c_off_w + 2;
    localparam logic [c_off_w-1:0] c_last_beat = c_off_w'(LINE_WORDS - 1);

    // Registered state and outputs
    logic [3:0]         r_cs;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [c_off_w-1:0] r_beat;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_wdata;
    logic               r_cpu_ready;
    logic [DW-1:0]      r_cpu_rdata;

    // Address fields of the live request (lookup) and the latched one
    logic [c_off_w-1:0] w_cpu_off;
    logic [c_idx_w-1:0] w_cpu_idx;
    logic [c_tag_w-1:0] w_cpu_tag;
    logic [c_off_w-1:0] w_r_off;
    logic [c_idx_w-1:0] w_r_idx;
    logic [c_tag_w-1:0] w_r_tag;
    logic [AW-1:0]      w_line_base;

    // Array interface
    logic               w_rd_valid;
    logic [c_tag_w-1:0] w_rd_tag;
    logic [DW-1:0]      w_rd_word;
    logic               w_hit;
    logic               w_wr_en;
    logic [c_off_w-1:0] w_wr_off;
    logic [DW-1:0]      w_wr_data;
    logic               w_set_en;
    logic               w_clr_en;
    logic [c_idx_w-1:0] w_clr_idx;
    logic               w_clr_all;

    assign w_cpu_off   = cpu_addr[c_lo-1:2];
    assign w_cpu_idx   = cpu_addr[c_lo+c_idx_w-1:c_lo];
    assign w_cpu_tag   = cpu_addr[AW-1:c_lo+c_idx_w];
    assign w_r_off     = r_addr[c_lo-1:2];
    assign w_r_idx     = r_addr[c_lo+c_idx_w-1:c_lo];
    assign w_r_tag     = r_addr[AW-1:c_lo+c_idx_w];
    assign w_line_base = {r_addr[AW-1:c_lo], {c_lo{1'b0}}};

    // Lookup is only acted on in IDLE, so it always uses the live address
    assign w_hit     = w_rd_valid && (w_rd_tag == w_cpu_tag);
    assign w_clr_all = ~rst;

    assign cs        = r_cs;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ready = r_cpu_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

`ifdef CACHE_FLUSH_EN
    localparam logic [c_idx_w-1:0] c_last_line = c_idx_w'(LINES - 1);
    logic [c_idx_w-1:0] r_fidx;

    assign w_clr_en  = rst && (r_cs == ST_FLUSH);
    assign w_clr_idx = r_fidx;
`else
    assign w_clr_en  = 1'b0;
    assign w_clr_idx = '0;
`endif

    // Array write strobes: refill beats and write hits; nothing during reset
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_off  = w_r_off;
        w_wr_data = r_wdata;
        w_set_en  = 1'b0;
        if (rst) begin
            if (r_cs == ST_FILL && mem_ack) begin
                w_wr_en   = 1'b1;
                w_wr_off  = r_beat;
                w_wr_data = mem_rdata;
                w_set_en  = (r_beat == c_last_beat);
            end else if (r_cs == ST_WRHIT) begin
                w_wr_en   = 1'b1;
            end
        end
    end

    cache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (c_idx_w),
        .OFF_W      (c_off_w),
        .TAG_W      (c_tag_w),
        .DW         (DW)
    ) u_array (
        .clk       (clk),
        .clr_all   (w_clr_all),
        .rd_index  (w_cpu_idx),
        .rd_offset (w_cpu_off),
        .rd_valid  (w_rd_valid),
        .rd_tag    (w_rd_tag),
        .rd_word   (w_rd_word),
        .wr_en     (w_wr_en),
        .wr_index  (w_r_idx),
        .wr_offset (w_wr_off),
        .wr_data   (w_wr_data),
        .set_en    (w_set_en),
        .set_index (w_r_idx),
        .set_tag   (w_r_tag),
        .clr_en    (w_clr_en),
        .clr_index (w_clr_idx)
    );

    // Controller FSM with registered CPU/memory handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cs        <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_beat      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
`ifdef CACHE_FLUSH_EN
            r_fidx      <= '0;
`endif
        end else begin
            // cpu_ready is a pulse raised only on entry to a completion state
            r_cpu_ready <= 1'b0;
            case (r_cs)
                ST_IDLE: begin
`ifdef CACHE_FLUSH_EN
                    if (flush) begin
                        r_fidx <= '0;
                        r_cs   <= ST_FLUSH;
                    end else
`endif
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        if (!cpu_we && w_hit) begin
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= w_rd_word;
                            r_cs        <= ST_RDHIT;
                        end else if (!cpu_we) begin
                            r_cs <= ST_RDMISS;
                        end else if (w_hit) begin
                            r_cs <= ST_WRHIT;
                        end else begin
                            r_cs <= ST_WRMISS;
                        end
                    end
                end
                ST_RDHIT: begin
                    r_cs <= ST_IDLE;
                end
                ST_RDMISS: begin
                    r_beat     <= '0;
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= w_line_base;
                    r_cs       <= ST_FILL;
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        r_beat <= r_beat + 1'b1;
                        // keep the requested word so RDDONE need not re-read the array
                        if (r_beat == w_r_off) begin
                            r_cpu_rdata <= mem_rdata;
                        end
                        if (r_beat == c_last_beat) begin
                            r_mem_req   <= 1'b0;
                            r_cpu_ready <= 1'b1;
                            r_cs        <= ST_RDDONE;
                        end else begin
                            r_mem_addr <= r_mem_addr + AW'(4);
                        end
                    end
                end
                ST_RDDONE: begin
                    r_cs <= ST_IDLE;
                end
                ST_WRHIT, ST_WRMISS: begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= r_wdata;
                    r_cs        <= ST_WRMEM;
                end
                ST_WRMEM: begin
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_cpu_ready <= 1'b1;
                        r_cs        <= ST_WRDONE;
                    end
                end
                ST_WRDONE: begin
                    r_cs <= ST_IDLE;
                end
`ifdef CACHE_FLUSH_EN
                ST_FLUSH: begin
                    if (r_fidx == c_last_line) begin
                        r_cs <= ST_IDLE;
                    end else begin
                        r_fidx <= r_fidx + 1'b1;
                    end
                end
`endif
                default: begin
                    r_cs <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
